// File: rtl/timer_pkg.sv
// Shared constants for timer_bank: per-channel register offsets, TCON bit
// positions and the byte stride between channel register blocks.
package timer_pkg;
    localparam logic [3:0] OFS_TH    = 4'h0;
    localparam logic [3:0] OFS_TL    = 4'h4;
    localparam logic [3:0] OFS_TCON  = 4'h8;
    localparam logic [3:0] OFS_PRESC = 4'hC;

    localparam int TCON_EN      = 0;
    localparam int TCON_IEN     = 1;
    localparam int TCON_PEND    = 2;
    localparam int TCON_ONESHOT = 3;

    localparam int CH_STRIDE = 16;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: reload/counter registers, TCON bits, overflow handling.
// The prescaler is built only when TIMER_PRESCALE_EN is defined.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int PRESC_W = 16
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               wr_th,
    input  logic               wr_tl,
    input  logic               wr_tcon,
    input  logic               wr_presc,
    input  logic [31:0]        wdata,
    output logic [WIDTH-1:0]   th,
    output logic [WIDTH-1:0]   tl,
    output logic [3:0]         tcon,
    output logic [PRESC_W-1:0] presc,
    output logic               irq
);
    logic [WIDTH-1:0] th_reg;
    logic [WIDTH-1:0] tl_reg;
    logic             en_reg;
    logic             ien_reg;
    logic             pend_reg;
    logic             oneshot_reg;
    logic             tick;
    logic             ovf;

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_W-1:0] presc_reg;
    logic [PRESC_W-1:0] pcnt_reg;

    assign tick  = en_reg && (pcnt_reg == '0);
    assign presc = presc_reg;

    // Enabling a stopped channel zeroes the prescaler so the first tick is immediate.
    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            presc_reg <= '0;
            pcnt_reg  <= '0;
        end else begin
            if (wr_presc)
                presc_reg <= wdata[PRESC_W-1:0];
            if (wr_tcon && wdata[TCON_EN] && !en_reg)
                pcnt_reg <= '0;
            else if (tick)
                pcnt_reg <= presc_reg;
            else if (en_reg)
                pcnt_reg <= pcnt_reg - PRESC_W'(1);
        end
    end
`else
    logic unused_presc;

    assign tick         = en_reg;
    assign presc        = '0;
    assign unused_presc = wr_presc;
`endif

    assign ovf = tick && (tl_reg == '1);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            th_reg      <= '0;
            tl_reg      <= '0;
            en_reg      <= 1'b0;
            ien_reg     <= 1'b0;
            pend_reg    <= 1'b0;
            oneshot_reg <= 1'b0;
        end else begin
            if (wr_th)
                th_reg <= wdata[WIDTH-1:0];

            // A CPU write to TL beats the reload/increment of the same cycle.
            if (wr_tl)
                tl_reg <= wdata[WIDTH-1:0];
            else if (ovf)
                tl_reg <= th_reg;
            else if (tick)
                tl_reg <= tl_reg + WIDTH'(1);

            if (wr_tcon) begin
                en_reg      <= wdata[TCON_EN];
                ien_reg     <= wdata[TCON_IEN];
                oneshot_reg <= wdata[TCON_ONESHOT];
            end else if (ovf && oneshot_reg) begin
                en_reg <= 1'b0;
            end

            // A new overflow wins over a simultaneous write-1-to-clear.
            if (ovf)
                pend_reg <= 1'b1;
            else if (wr_tcon && wdata[TCON_PEND])
                pend_reg <= 1'b0;
        end
    end

    assign th   = th_reg;
    assign tl   = tl_reg;
    assign tcon = {oneshot_reg, pend_reg, ien_reg, en_reg};
    assign irq  = pend_reg & ien_reg;
endmodule

// File: rtl/timer_bank.sv
// Multi-channel bus timer: address decode, read mux and IRQ combine around
// NUM_CH timer_channel instances. Prescalers exist only with TIMER_PRESCALE_EN.
module timer_bank
    import timer_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0100,
    parameter int          PRESC_W   = 16
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              rd,
    input  logic              wr,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              irqout,
    output logic [NUM_CH-1:0] irq_vec
);
    logic [31:0] offset;
    logic        hit;
    logic [27:0] ch_num;
    logic [3:0]  reg_ofs;
    logic        unused_bits;
    logic [31:0] ch_rdata [NUM_CH];

    // Addresses below the base wrap to large offsets and fail the range check.
    assign offset      = addr - BASE_ADDR;
    assign hit         = offset < 32'(CH_STRIDE * NUM_CH);
    assign ch_num      = offset[31:4];
    assign reg_ofs     = {offset[3:2], 2'b00};
    assign unused_bits = ^offset[1:0];

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic               sel_ch;
            logic               we;
            logic [WIDTH-1:0]   th;
            logic [WIDTH-1:0]   tl;
            logic [3:0]         tcon;
            logic [PRESC_W-1:0] presc;
            logic [31:0]        rd_val;

            assign sel_ch = hit && (ch_num == 28'(gi));
            assign we     = wr && sel_ch;

            timer_channel #(
                .WIDTH   (WIDTH),
                .PRESC_W (PRESC_W)
            ) u_ch (
                .sysclk   (sysclk),
                .reset    (reset),
                .wr_th    (we && (reg_ofs == OFS_TH)),
                .wr_tl    (we && (reg_ofs == OFS_TL)),
                .wr_tcon  (we && (reg_ofs == OFS_TCON)),
                .wr_presc (we && (reg_ofs == OFS_PRESC)),
                .wdata    (wdata),
                .th       (th),
                .tl       (tl),
                .tcon     (tcon),
                .presc    (presc),
                .irq      (irq_vec[gi])
            );

            always_comb begin
                rd_val = '0;
                case (reg_ofs)
                    OFS_TH:    rd_val = 32'(th);
                    OFS_TL:    rd_val = 32'(tl);
                    OFS_TCON:  rd_val = 32'(tcon);
                    OFS_PRESC: rd_val = 32'(presc);
                    default:   rd_val = '0;
                endcase
            end

            assign ch_rdata[gi] = (rd && sel_ch) ? rd_val : '0;
        end
    endgenerate

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++)
            rdata = rdata | ch_rdata[i];
    end

    assign irqout = |irq_vec;
endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus random bus
// traffic compared against a behavioural register/counter model.
module tb_timer_bank;
    localparam logic [31:0] BASE = 32'h4000_0100;
    localparam int          NCH  = 2;

    logic           sysclk = 1'b0;
    logic           reset;
    logic           rd, wr;
    logic [31:0]    addr, wdata, rdata;
    logic           irqout;
    logic [NCH-1:0] irq_vec;

    logic        rd8, wr8;
    logic [31:0] addr8, wdata8, rdata8;
    logic        irqout8;
    logic [2:0]  irq_vec8;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]    last_rdata, last_rdata8;
    logic           last_irq, last_irq8;
    logic [NCH-1:0] last_vec;
    logic [2:0]     last_vec8;

    // Behavioural model of the default-configuration DUT
    logic [31:0] m_th [NCH], m_tl [NCH], m_presc [NCH], m_pcnt [NCH];
    bit          m_en [NCH], m_ien [NCH], m_pend [NCH], m_os [NCH];

    always #5 sysclk = ~sysclk;

    timer_bank dut (
        .sysclk (sysclk), .reset (reset), .rd (rd), .wr (wr),
        .addr (addr), .wdata (wdata), .rdata (rdata),
        .irqout (irqout), .irq_vec (irq_vec)
    );

    timer_bank #(.NUM_CH(3), .WIDTH(8)) dut8 (
        .sysclk (sysclk), .reset (reset), .rd (rd8), .wr (wr8),
        .addr (addr8), .wdata (wdata8), .rdata (rdata8),
        .irqout (irqout8), .irq_vec (irq_vec8)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_th[c] = 0; m_tl[c] = 0; m_presc[c] = 0; m_pcnt[c] = 0;
            m_en[c] = 0; m_ien[c] = 0; m_pend[c] = 0; m_os[c] = 0;
        end
    endfunction

    function automatic int addr_ch(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        if (o >= 32'(16 * NCH)) return -1;
        return int'(o / 16);
    endfunction

    function automatic int addr_ofs(input logic [31:0] a);
        logic [31:0] o;
        o = a - BASE;
        return int'(o % 16) / 4 * 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int c;
        c = addr_ch(a);
        if (c < 0) return 0;
        case (addr_ofs(a))
            0:  return m_th[c];
            4:  return m_tl[c];
            8:  return {28'd0, m_os[c], m_pend[c], m_ien[c], m_en[c]};
`ifdef TIMER_PRESCALE_EN
            12: return m_presc[c];
`endif
            default: return 0;
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_vec();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_pend[c] & m_ien[c];
        return v;
    endfunction

    // One clock edge of the model, using the bus values presented this cycle
    function automatic void model_step();
        int wc, wo;
        wc = wr ? addr_ch(addr) : -1;
        wo = addr_ofs(addr);
        for (int c = 0; c < NCH; c++) begin
            bit tick, wrap, n_en, n_pend;
            logic [31:0] n_tl, n_pcnt;
            tick = m_en[c];
`ifdef TIMER_PRESCALE_EN
            tick = tick && (m_pcnt[c] == 0);
`endif
            wrap   = tick && (m_tl[c] == 32'hFFFF_FFFF);
            n_tl   = !tick ? m_tl[c] : (wrap ? m_th[c] : m_tl[c] + 1);
            n_en   = m_en[c] && !(wrap && m_os[c]);
            n_pend = m_pend[c] || wrap;
            n_pcnt = tick ? m_presc[c] : (m_en[c] ? m_pcnt[c] - 1 : m_pcnt[c]);
            if (wc == c) begin
                case (wo)
                    0: m_th[c] = wdata;
                    4: n_tl = wdata;
                    8: begin
                        if (wdata[0] && !m_en[c]) n_pcnt = 0;
                        n_en = wdata[0];
                        m_ien[c] = wdata[1];
                        m_os[c] = wdata[3];
                        if (wdata[2] && !wrap) n_pend = 0;
                    end
`ifdef TIMER_PRESCALE_EN
                    12: m_presc[c] = wdata & 32'h0000_FFFF;
`endif
                    default: ;
                endcase
            end
            m_tl[c] = n_tl; m_en[c] = n_en; m_pend[c] = n_pend; m_pcnt[c] = n_pcnt;
        end
    endfunction

    task automatic step();
        @(negedge sysclk);
        last_rdata = rdata; last_rdata8 = rdata8;
        last_irq = irqout; last_irq8 = irqout8;
        last_vec = irq_vec; last_vec8 = irq_vec8;
        if (rd) chk("rdata_model", rdata, model_read(addr));
        chk("irqout_model", 32'(irqout), 32'(|model_vec()));
        chk("irq_vec_model", 32'(irq_vec), 32'(model_vec()));
        @(posedge sysclk);
        if (reset) model_step();
        #1;
        rd = 0; wr = 0; rd8 = 0; wr8 = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic bus_wr(input int c, input int o, input logic [31:0] d);
        wr = 1; addr = BASE + 32'(c * 16 + o); wdata = d;
        step();
    endtask

    task automatic rd_exp(input string tag, input int c, input int o, input logic [31:0] e);
        rd = 1; addr = BASE + 32'(c * 16 + o);
        step();
        chk(tag, last_rdata, e);
    endtask

    task automatic wr8_reg(input logic [31:0] a, input logic [31:0] d);
        wr8 = 1; addr8 = a; wdata8 = d;
        step();
    endtask

    task automatic rd8_exp(input string tag, input logic [31:0] a, input logic [31:0] e);
        rd8 = 1; addr8 = a;
        step();
        chk(tag, last_rdata8, e);
    endtask

    initial begin
        int op, c, o;
        logic [31:0] a, d;
        reset = 0; rd = 0; wr = 0; addr = 0; wdata = 0;
        rd8 = 0; wr8 = 0; addr8 = 0; wdata8 = 0;
        model_reset();
        idle(3);
        reset = 1;
        idle(1);

        // Reset asserted mid-count
        bus_wr(0, 4, 32'h1234);
        bus_wr(1, 0, 0);
        bus_wr(1, 4, 32'hFFFF_FFFF);
        bus_wr(1, 8, 32'h3);
        bus_wr(0, 8, 32'h1);
        rd_exp("t1_tl_pre", 0, 4, 32'h1234);
        chk("t1_irq_pre", 32'(last_irq), 1);
        rd = 1; addr = BASE + 4;
        #2 reset = 0;
        model_reset();
        #1;
        chk("t1_rdata_async", rdata, 0);
        chk("t1_irq_async", 32'(irqout), 0);
        chk("t1_vec_async", 32'(irq_vec), 0);
        step();
        for (int i = 0; i < 8; i++) rd_exp("t1_reg_in_rst", i / 4, (i % 4) * 4, 0);
        reset = 1;
        idle(2);
        rd_exp("t1_tl_post", 0, 4, 0);
        rd_exp("t1_tcon_post", 0, 8, 0);

        // Periodic reload, pending, W1C
        bus_wr(0, 0, 32'hFFFF_FFFC);
        bus_wr(0, 4, 32'hFFFF_FFFC);
        bus_wr(0, 8, 32'h3);
        idle(4);
        rd_exp("t2_tl_reload", 0, 4, 32'hFFFF_FFFC);
        rd_exp("t2_pend", 0, 8, 32'h7);
        chk("t2_irqout", 32'(last_irq), 1);
        bus_wr(0, 8, 32'h7);
        rd_exp("t2_w1c", 0, 8, 32'h3);
        chk("t2_irq_fall", 32'(last_irq), 0);
        rd_exp("t2_repeat", 0, 8, 32'h7);
        bus_wr(0, 8, 32'h4);

        // One-shot on channel 1
        bus_wr(1, 0, 0);
        bus_wr(1, 4, 32'hFFFF_FFFE);
        bus_wr(1, 8, 32'hB);
        idle(2);
        rd_exp("t3_tcon", 1, 8, 32'hE);
        chk("t3_vec", 32'(last_vec), 32'h2);
        rd_exp("t3_tl", 1, 4, 0);

        // Same-cycle W1C/overflow and TL write/overflow
        bus_wr(0, 0, 0);
        bus_wr(0, 4, 32'hFFFF_FFFF);
        bus_wr(0, 8, 32'h3);
        bus_wr(0, 8, 32'h7);
        rd_exp("t5_w1c_vs_ovf", 0, 8, 32'h7);
        bus_wr(0, 8, 32'h4);
        bus_wr(0, 4, 32'hFFFF_FFFF);
        bus_wr(0, 8, 32'h3);
        bus_wr(0, 4, 32'h10);
        rd_exp("t5_tl_wr_vs_ovf", 0, 4, 32'h10);
        rd_exp("t5_pend_set", 0, 8, 32'h7);
        bus_wr(0, 8, 32'h4);

        // Prescaler
        bus_wr(1, 12, 32'h3);
        bus_wr(1, 4, 0);
        bus_wr(1, 8, 32'h5);
        idle(8);
`ifdef TIMER_PRESCALE_EN
        rd_exp("t4_tl_presc", 1, 4, 32'h2);
        rd_exp("t4_presc_rd", 1, 12, 32'h3);
`else
        rd_exp("t4_tl_noprsc", 1, 4, 32'h8);
        rd_exp("t4_presc_rd", 1, 12, 0);
`endif
        bus_wr(1, 8, 32'h4);

        // 8-bit, three-channel instance
        wr8_reg(BASE + 32'h20, 32'hFFFF_FF80);
        wr8_reg(BASE + 32'h24, 32'hFFFF_FFFF);
        wr8_reg(BASE + 32'h28, 32'h3);
        step();
        rd8_exp("t6_reload", BASE + 32'h24, 32'h80);
        chk("t6_vec", 32'(last_vec8), 32'h4);
        chk("t6_irqout", 32'(last_irq8), 1);
        rd8_exp("t6_tcon", BASE + 32'h28, 32'h7);
        wr8_reg(BASE + 32'h30, 32'h5A);
        rd8_exp("t6_oor_rd", BASE + 32'h30, 0);
        rd8_exp("t6_ch0_th", BASE, 0);
        rd8_exp("t6_th", BASE + 32'h20, 32'h80);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 9);
            c  = $urandom_range(0, 2);
            o  = $urandom_range(0, 3) * 4;
            a  = BASE + 32'(c * 16 + o);
            if ($urandom_range(0, 15) == 0) a = BASE - 32'(4 * $urandom_range(1, 4));
            if (op <= 3) begin
                step();
            end else if (op <= 6) begin
                rd = 1; addr = a;
                step();
            end else begin
                d = $urandom();
                if (o == 4 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
                if (o == 0 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
                if (o == 8) d = 32'($urandom_range(0, 15)) | (($urandom_range(0, 2) != 0) ? 32'h1 : 32'h0);
                if (o == 12) d = 32'($urandom_range(0, 3));
                wr = 1; addr = a; wdata = d;
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
